video_out_buf: RTL and testbench
================================

Name: video_out_buf

Overview:
- Read-side counterpart of the video input path. Pulls 64-bit pixel words from the PCS-to-video async FIFO read port, which is in the video clock domain.
- Regenerates raster timing (vsyn/hsyn/de) and outputs 24-bit pixels.
- Discards the zero padding words that the transmit side appends after each frame.
- Detects and counts FIFO underflow.

Parameters:
- P_HFP, 88, horizontal front porch (clocks)
- P_HSYNC, 44, hsync width (clocks)
- P_HBP, 148, horizontal back porch (clocks)
- P_VFP, 4, vertical front porch (lines)
- P_VSYNC, 5, vsync width (lines)
- P_VBP, 36, vertical back porch (lines)
- P_DRAIN_MAX, 480, max padding words discarded per frame
- P_UF_COLOR, 24'h000000, pixel value output on underflow

Ports:
- i_video_clk  in  1  video pixel clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_enable  in  1  start/continue frame output
- i_width  in  13  active pixels per line
- i_heigh  in  13  active lines per frame
- i_fifo_dout  in  64  FIFO read data; pixel in [23:0], [63:24] ignored
- i_fifo_empty  in  1  FIFO empty
- i_fifo_almostempty  in  1  FIFO prog_empty
- o_fifo_rd_en  out  1  FIFO read strobe
- o_vsyn  out  1  vertical sync, active high
- o_hsyn  out  1  horizontal sync, active high
- o_de  out  1  active video
- o_video_data  out  24  pixel
- o_frame_start  out  1  1-clk pulse, aligned with first o_de of a frame
- o_underflow  out  1  1-clk pulse per underflowed pixel, aligned with that pixel's o_de
- o_underflow_cnt  out  16  saturating underflow count; cleared by reset only
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Counters 0.
- Reset is an async assert; deassertion is synchronous via a flop. Reset mid-frame aborts immediately and outputs return to 0.
- FSM states: IDLE, PRIME, RUN, DRAIN.
- IDLE -> PRIME when i_enable=1, i_width!=0 and i_heigh!=0. On this transition, latch width/height into w_lat/h_lat; they are constant for the whole frame.
- PRIME -> RUN when i_fifo_almostempty=0. h_cnt and v_cnt start at 0.
- Geometry: HTOT = w_lat+P_HFP+P_HSYNC+P_HBP, VTOT = h_lat+P_VFP+P_VSYNC+P_VBP. All 13-bit arithmetic; widths fit without overflow.
- RUN counters:
  - h_cnt counts 0..HTOT-1 and wraps.
  - v_cnt increments on h_cnt wrap.
- RUN timing:
  - internal de = (h_cnt<w_lat)&&(v_cnt<h_lat).
  - hsync = w_lat+P_HFP <= h_cnt < w_lat+P_HFP+P_HSYNC, on every line.
  - vsync = h_lat+P_VFP <= v_cnt < h_lat+P_VFP+P_VSYNC, whole lines.
- RUN read strobe: o_fifo_rd_en = internal de & ~i_fifo_empty.
- FIFO has 1-clk read latency. Pipeline:
  - stage1 registers timing, de and rd_en.
  - stage2 registers outputs, with o_video_data = stage1 rd_en ? i_fifo_dout[23:0] : P_UF_COLOR.
  - Total latency from internal timing to outputs is 2 clk, identical for de, hsyn, vsyn and data.
- Underflow: internal de=1 with i_fifo_empty=1 means no read. Two clocks later o_de=1, o_video_data=P_UF_COLOR, o_underflow=1, and o_underflow_cnt increments (saturates at 16'hFFFF). No catch-up reads follow.
- RUN -> DRAIN at the clock after the last active pixel (h_cnt==w_lat-1, v_cnt==h_lat-1). Timing counters keep running in DRAIN.
- DRAIN: o_fifo_rd_en = ~i_fifo_empty while drain_cnt < P_DRAIN_MAX. drain_cnt counts issued reads; data is discarded and o_de stays 0.
- Drain stops when drain_cnt reaches the limit or the FIFO goes empty. There is no early exit.
- End of frame (h_cnt==HTOT-1, v_cnt==VTOT-1), from DRAIN:
  - i_enable=1: relatch geometry and go to RUN directly; no PRIME after the first frame.
  - i_enable=0: go to IDLE.
  - Either way, reset drain_cnt.
- i_enable falling mid-frame completes the current frame including blanking, then IDLE.
- i_width/i_heigh changes take effect only at a frame boundary.
- o_frame_start pulses with o_de for the pixel h_cnt=0, v_cnt=0.

Test Plan:
- Bench geometry: P_HFP=2, P_HSYNC=2, P_HBP=2, P_VFP=1, P_VSYNC=1, P_VBP=1, P_DRAIN_MAX=4, width=8, height=4, giving HTOT=14 and VTOT=7.
- Basic frame: FIFO preloaded with 32 incrementing words plus 4 zero pad words, i_enable=1 -> exactly 32 o_de clocks in 4 runs of 8 with data 1..32 in order; hsyn high 2 clk starting 2 clk after each de run; vsyn high for 14 clk on line 5; o_frame_start once; FIFO empty after DRAIN.
- Latency: first o_fifo_rd_en at clock T -> o_de=1 and o_video_data=word0 at T+2; o_frame_start=1 at T+2.
- Underflow: force i_fifo_empty=1 for pixels 3..4 of line 0 -> those pixels output 000000, o_underflow pulses twice, o_underflow_cnt=2; remaining pixels output next words in sequence with no skip.
- Drain limit: 10 pad words queued after the frame -> exactly 4 discard reads, 6 words remain, none appear on o_de.
- Enable/geometry change: deassert i_enable mid-frame -> frame completes, then o_busy=0 and all outputs 0; change width to 4 mid-frame with enable held -> new width applies only from the next frame.
- Reset mid-RUN: assert i_rst_n=0 at line 2 -> all outputs 0 immediately; after release, the block waits in IDLE/PRIME until i_enable=1 and i_fifo_almostempty=0.

Source files
------------

// File: rtl/video_out_buf.sv
// video_out_buf
//   Read side of the PCS-to-video path. Pulls 64-bit words from an async FIFO
//   read port (already in the video clock domain), regenerates raster timing
//   and drives 24-bit pixels. Discards the zero padding the transmitter
//   appends after each frame and counts FIFO underflows.
//
// Ports
//   i_video_clk, i_rst_n        pixel clock, async active-low reset
//   i_enable                    start / continue frame output
//   i_width, i_heigh            active geometry, sampled at frame boundaries
//   i_fifo_dout/empty/almostempty, o_fifo_rd_en   FIFO read port (1-clk latency)
//   o_vsyn, o_hsyn, o_de, o_video_data            raster output
//   o_frame_start               pulse with the first o_de of a frame
//   o_underflow, o_underflow_cnt  per-pixel underflow pulse, saturating count
//   o_busy                      FSM not idle
//   o_dbg_state                 current FSM state for debug / checkers
//
// Handshake: the FIFO read port has no ready; o_fifo_rd_en is only raised
// while i_fifo_empty is low, and the word is consumed on that same clock.
// Data for a read issued in cycle T is valid on i_fifo_dout in cycle T+1.
module video_out_buf #(
  parameter int unsigned P_HFP       = 88,
  parameter int unsigned P_HSYNC     = 44,
  parameter int unsigned P_HBP       = 148,
  parameter int unsigned P_VFP       = 4,
  parameter int unsigned P_VSYNC     = 5,
  parameter int unsigned P_VBP       = 36,
  parameter int unsigned P_DRAIN_MAX = 480,
  parameter logic [23:0] P_UF_COLOR  = 24'h000000
) (
  input  logic        i_video_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [12:0] i_width,
  input  logic [12:0] i_heigh,
  input  logic [63:0] i_fifo_dout,
  input  logic        i_fifo_empty,
  input  logic        i_fifo_almostempty,
  output logic        o_fifo_rd_en,
  output logic        o_vsyn,
  output logic        o_hsyn,
  output logic        o_de,
  output logic [23:0] o_video_data,
  output logic        o_frame_start,
  output logic        o_underflow,
  output logic [15:0] o_underflow_cnt,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  localparam logic [12:0] L_HFP    = 13'(P_HFP);
  localparam logic [12:0] L_HSYNC  = 13'(P_HSYNC);
  localparam logic [12:0] L_HBLANK = 13'(P_HFP + P_HSYNC + P_HBP);
  localparam logic [12:0] L_VFP    = 13'(P_VFP);
  localparam logic [12:0] L_VSYNC  = 13'(P_VSYNC);
  localparam logic [12:0] L_VBLANK = 13'(P_VFP + P_VSYNC + P_VBP);
  localparam int          DW       = $clog2(P_DRAIN_MAX + 1);
  localparam logic [DW-1:0] L_DMAX = DW'(P_DRAIN_MAX);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

  // Upper FIFO bits carry no pixel information.
  logic dout_unused;
  assign dout_unused = ^i_fifo_dout[63:24];

  // Reset asserts asynchronously, releases on a clock edge.
  logic rst_sync_n_q;
  always_ff @(posedge i_video_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_n_q <= 1'b0;
    else          rst_sync_n_q <= 1'b1;
  end

  state_t        state_q, state_d;
  logic [12:0]   w_lat_q, w_lat_d, h_lat_q, h_lat_d;
  logic [12:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;

  logic timing_on, de_int, hs_int, vs_int, fs_int, pix_rd, drain_rd;
  logic h_end, v_end, last_pix, geom_ok;
  logic [12:0] h_adv, v_adv;

  always_comb begin
    timing_on = (state_q == S_RUN) || (state_q == S_DRAIN);
    h_end     = (h_cnt_q == w_lat_q + L_HBLANK - 13'd1);
    v_end     = (v_cnt_q == h_lat_q + L_VBLANK - 13'd1);
    last_pix  = (h_cnt_q == w_lat_q - 13'd1) && (v_cnt_q == h_lat_q - 13'd1);
    geom_ok   = (i_width != 13'd0) && (i_heigh != 13'd0);
    h_adv     = h_end ? 13'd0 : h_cnt_q + 13'd1;
    v_adv     = h_end ? (v_end ? 13'd0 : v_cnt_q + 13'd1) : v_cnt_q;

    de_int = (state_q == S_RUN) && (h_cnt_q < w_lat_q) && (v_cnt_q < h_lat_q);
    hs_int = timing_on && (h_cnt_q >= w_lat_q + L_HFP) &&
             (h_cnt_q < w_lat_q + L_HFP + L_HSYNC);
    vs_int = timing_on && (v_cnt_q >= h_lat_q + L_VFP) &&
             (v_cnt_q < h_lat_q + L_VFP + L_VSYNC);
    fs_int = de_int && (h_cnt_q == 13'd0) && (v_cnt_q == 13'd0);

    // An empty FIFO during active video is an underflow: no read, no catch-up.
    pix_rd   = de_int && !i_fifo_empty;
    drain_rd = (state_q == S_DRAIN) && !i_fifo_empty && (drain_cnt_q < L_DMAX);
    o_fifo_rd_en = pix_rd || drain_rd;
    o_busy       = (state_q != S_IDLE);
    o_dbg_state  = state_q;
  end

  always_comb begin
    state_d     = state_q;
    w_lat_d     = w_lat_q;
    h_lat_d     = h_lat_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        h_cnt_d     = 13'd0;
        v_cnt_d     = 13'd0;
        drain_cnt_d = '0;
        if (i_enable && geom_ok) begin
          w_lat_d = i_width;
          h_lat_d = i_heigh;
          state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        if (!i_fifo_almostempty) state_d = S_RUN;
      end
      S_RUN: begin
        h_cnt_d = h_adv;
        v_cnt_d = v_adv;
        if (last_pix) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        h_cnt_d = h_adv;
        v_cnt_d = v_adv;
        if (drain_rd) drain_cnt_d = drain_cnt_q + 1'b1;
        if (h_end && v_end) begin
          drain_cnt_d = '0;
          // Back-to-back frames skip PRIME; geometry is resampled here only.
          if (i_enable && geom_ok) begin
            w_lat_d = i_width;
            h_lat_d = i_heigh;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_video_clk or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      state_q     <= S_IDLE;
      w_lat_q     <= 13'd0;
      h_lat_q     <= 13'd0;
      h_cnt_q     <= 13'd0;
      v_cnt_q     <= 13'd0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      w_lat_q     <= w_lat_d;
      h_lat_q     <= h_lat_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Two-stage output pipeline: stage 1 waits out the FIFO read latency,
  // stage 2 merges the returned word so all outputs share a 2-clk delay.
  logic s1_de_q, s1_hs_q, s1_vs_q, s1_fs_q, s1_rd_q;

  always_ff @(posedge i_video_clk or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      s1_de_q         <= 1'b0;
      s1_hs_q         <= 1'b0;
      s1_vs_q         <= 1'b0;
      s1_fs_q         <= 1'b0;
      s1_rd_q         <= 1'b0;
      o_de            <= 1'b0;
      o_hsyn          <= 1'b0;
      o_vsyn          <= 1'b0;
      o_video_data    <= 24'd0;
      o_frame_start   <= 1'b0;
      o_underflow     <= 1'b0;
      o_underflow_cnt <= 16'd0;
    end else begin
      s1_de_q       <= de_int;
      s1_hs_q       <= hs_int;
      s1_vs_q       <= vs_int;
      s1_fs_q       <= fs_int;
      s1_rd_q       <= pix_rd;
      o_de          <= s1_de_q;
      o_hsyn        <= s1_hs_q;
      o_vsyn        <= s1_vs_q;
      o_frame_start <= s1_fs_q;
      o_video_data  <= s1_rd_q ? i_fifo_dout[23:0] : P_UF_COLOR;
      o_underflow   <= s1_de_q && !s1_rd_q;
      if (s1_de_q && !s1_rd_q && (o_underflow_cnt != 16'hFFFF))
        o_underflow_cnt <= o_underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_out_buf.sv
// Testbench for video_out_buf: a table of frame scenarios (fixed corner
// cases plus randomized ones) is run against a frame-level reference model;
// hand-written sequences cover reset-in-frame and the PRIME wait.
module tb_video_out_buf;

  localparam int HFP = 2, HS = 2, HBP = 2, VFP = 1, VS = 1, VBP = 1, DMAX = 4;
  localparam logic [23:0] UF = 24'h000000;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        uf;
    logic [23:0] data;
  } out_t;

  typedef struct {
    int n_frames;
    int w0, w1, h0, h1;
    int pad;
    int n_short;
    int f_lo, f_hi;
    bit rnd_data;
    int exp_uf;
    int exp_left;
  } scen_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst_n, i_enable, i_fifo_empty, i_fifo_almostempty;
  logic [12:0] i_width, i_heigh;
  logic [63:0] i_fifo_dout;
  logic        o_fifo_rd_en, o_vsyn, o_hsyn, o_de, o_frame_start, o_underflow, o_busy;
  logic [23:0] o_video_data;
  logic [15:0] o_underflow_cnt;
  logic [1:0]  o_dbg_state;

  video_out_buf #(
    .P_HFP(HFP), .P_HSYNC(HS), .P_HBP(HBP),
    .P_VFP(VFP), .P_VSYNC(VS), .P_VBP(VBP),
    .P_DRAIN_MAX(DMAX), .P_UF_COLOR(UF)
  ) dut (
    .i_video_clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .i_width(i_width), .i_heigh(i_heigh),
    .i_fifo_dout(i_fifo_dout), .i_fifo_empty(i_fifo_empty),
    .i_fifo_almostempty(i_fifo_almostempty), .o_fifo_rd_en(o_fifo_rd_en),
    .o_vsyn(o_vsyn), .o_hsyn(o_hsyn), .o_de(o_de), .o_video_data(o_video_data),
    .o_frame_start(o_frame_start), .o_underflow(o_underflow),
    .o_underflow_cnt(o_underflow_cnt), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // scoreboard
  logic [63:0] fifo_q[$];
  logic [28:0] exp_q[$];
  logic        rd_q[$];
  int n_vec = 0, n_err = 0;
  int total_k, len0, uf_model, left_model, uf_total;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // driver: one clock, FIFO model included (pop on read, 1-clk latency)
  task automatic step(input bit en, input int w, input int h, input bit force_e);
    bit rd;
    rd = o_fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd) begin
      if (fifo_q.size() > 0) i_fifo_dout = fifo_q.pop_front();
      else check("read_of_empty_fifo", 1, 0);
    end
    i_enable           = en;
    i_width            = 13'(w);
    i_heigh            = 13'(h);
    i_fifo_empty       = force_e || (fifo_q.size() == 0);
    i_fifo_almostempty = (fifo_q.size() < 2);
    @(negedge clk);
  endtask

  // Reference model: walks each frame's raster position by position,
  // treating the FIFO as an ordered list of words.
  task automatic build_model(input scen_t s);
    logic [63:0] mq[$];
    logic [63:0] wd;
    logic [23:0] lo;
    int k, wf, hf, htot, vtot, dcnt, nw, word_val;
    bit in_drain, empty, rd;
    out_t o;
    fifo_q.delete(); exp_q.delete(); rd_q.delete();
    word_val = 1;
    uf_model = 0;
    for (int f = 0; f < s.n_frames; f++) begin
      wf = (f == 0) ? s.w0 : s.w1;
      hf = (f == 0) ? s.h0 : s.h1;
      nw = wf * hf - ((f == s.n_frames - 1) ? s.n_short : 0);
      for (int i = 0; i < nw; i++) begin
        lo = s.rnd_data ? 24'($urandom()) : 24'(word_val);
        word_val++;
        fifo_q.push_back({$urandom(), 8'($urandom()), lo});
      end
      for (int i = 0; i < s.pad; i++) fifo_q.push_back(64'h0);
    end
    mq = fifo_q;
    k = 0;
    for (int f = 0; f < s.n_frames; f++) begin
      wf = (f == 0) ? s.w0 : s.w1;
      hf = (f == 0) ? s.h0 : s.h1;
      htot = wf + HFP + HS + HBP;
      vtot = hf + VFP + VS + VBP;
      if (f == 0) len0 = htot * vtot;
      in_drain = 0;
      dcnt = 0;
      for (int v = 0; v < vtot; v++) begin
        for (int hh = 0; hh < htot; hh++) begin
          o = '0;
          rd = 0;
          empty = (k >= s.f_lo && k <= s.f_hi) || (mq.size() == 0);
          o.de = (hh < wf) && (v < hf);
          o.hs = (hh >= wf + HFP) && (hh < wf + HFP + HS);
          o.vs = (v >= hf + VFP) && (v < hf + VFP + VS);
          o.fs = o.de && hh == 0 && v == 0;
          if (o.de) begin
            if (empty) begin
              o.uf = 1'b1;
              o.data = UF;
              uf_model++;
            end else begin
              wd = mq.pop_front();
              o.data = wd[23:0];
              rd = 1;
            end
          end else if (in_drain && dcnt < DMAX && !empty) begin
            wd = mq.pop_front();
            rd = 1;
            dcnt++;
          end
          if (o.de && hh == wf - 1 && v == hf - 1) in_drain = 1;
          exp_q.push_back(o);
          rd_q.push_back(rd);
          k++;
        end
      end
    end
    total_k = k;
    left_model = mq.size();
  endtask

  task automatic run_scen(input int idx, input scen_t s);
    int first_rd, first_de, first_fs, drop_k, kin;
    logic [28:0] got, exp;
    logic exp_rd, exp_busy;
    build_model(s);
    drop_k = (s.n_frames == 2) ? len0 + 5 : 5;
    i_width = 13'(s.w0);
    i_heigh = 13'(s.h0);
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_almostempty = (fifo_q.size() < 2);
    i_enable = 1'b1;
    first_rd = -1; first_de = -1; first_fs = -1;
    for (int c = 0; c < total_k + 8; c++) begin
      kin = c - 1;
      step(kin < drop_k, (kin >= 20) ? s.w1 : s.w0, (kin >= 20) ? s.h1 : s.h0,
           (kin >= s.f_lo) && (kin <= s.f_hi));
      got = {o_de, o_hsyn, o_vsyn, o_frame_start, o_underflow, o_video_data};
      exp = (c >= 3 && exp_q.size() > 0) ? exp_q.pop_front() : '0;
      exp_rd = (kin >= 0 && rd_q.size() > 0) ? rd_q.pop_front() : 1'b0;
      exp_busy = (kin < total_k);
      check($sformatf("s%0d_cyc%0d", idx, c), {got, o_fifo_rd_en, o_busy}, {exp, exp_rd, exp_busy});
      if (first_rd < 0 && o_fifo_rd_en) first_rd = c;
      if (first_de < 0 && o_de) first_de = c;
      if (first_fs < 0 && o_frame_start) first_fs = c;
    end
    check($sformatf("s%0d_fifo_left", idx), fifo_q.size(),
          (s.exp_left >= 0) ? s.exp_left : left_model);
    uf_total += (s.exp_uf >= 0) ? s.exp_uf : uf_model;
    check($sformatf("s%0d_uf_cnt", idx), o_underflow_cnt, uf_total);
    if (idx == 0) begin
      check("lat_first_rd", first_rd, 1);
      check("lat_rd_to_de", first_de - first_rd, 2);
      check("lat_frame_start", first_fs, first_de);
    end
  endtask

  scen_t sc[9];

  initial begin
    bit seen;
    // vectors: n_frames, w0, w1, h0, h1, pad, n_short, f_lo, f_hi, rnd, exp_uf, exp_left
    sc[0] = '{1, 8, 6, 4, 3, 4,  0, 1000, 1000, 1'b0, 0, 0};  // basic, mid-frame width change ignored
    sc[1] = '{1, 8, 8, 4, 4, 4,  0, 3,    4,    1'b0, 2, 2};  // forced underflow, pixels 3..4
    sc[2] = '{1, 8, 8, 4, 4, 10, 0, 1000, 1000, 1'b0, 0, 6};  // drain limit
    sc[3] = '{2, 8, 4, 4, 4, 4,  0, 1000, 1000, 1'b0, 0, 0};  // width 4 from next frame
    sc[4] = '{1, 8, 8, 4, 4, 0,  2, 1000, 1000, 1'b0, 2, 0};  // FIFO runs dry at frame end
    for (int i = 5; i < 9; i++) begin
      sc[i].n_frames = $urandom_range(1, 2);
      sc[i].w0 = $urandom_range(1, 12);
      sc[i].w1 = $urandom_range(1, 12);
      sc[i].h0 = $urandom_range(1, 4);
      sc[i].h1 = $urandom_range(1, 4);
      sc[i].pad = $urandom_range(2, 8);
      sc[i].n_short = $urandom_range(0, 3);
      sc[i].f_lo = $urandom_range(0, 40);
      sc[i].f_hi = sc[i].f_lo + $urandom_range(0, 3);
      sc[i].rnd_data = 1'b1;
      sc[i].exp_uf = -1;
      sc[i].exp_left = -1;
    end

    i_rst_n = 1'b0; i_enable = 1'b0; i_width = 13'd8; i_heigh = 13'd4;
    i_fifo_dout = 64'h0; i_fifo_empty = 1'b1; i_fifo_almostempty = 1'b1;
    uf_total = 0;
    #1;
    check("reset_outputs", {o_de, o_hsyn, o_vsyn, o_frame_start, o_underflow, o_video_data,
                            o_fifo_rd_en, o_busy, o_underflow_cnt, o_dbg_state}, 0);
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (3) step(0, 8, 4, 0);
    check("idle_after_reset", {o_de, o_video_data, o_fifo_rd_en, o_busy, o_underflow_cnt}, 0);

    for (int i = 0; i < 9; i++) run_scen(i, sc[i]);

    // Reset on line 2 of a running frame.
    build_model(sc[0]);
    i_enable = 1'b1;
    repeat (34) step(1, 8, 4, 0);
    check("busy_mid_frame", o_busy, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("reset_mid_run", {o_de, o_hsyn, o_vsyn, o_frame_start, o_underflow, o_video_data,
                            o_fifo_rd_en, o_busy, o_underflow_cnt}, 0);
    i_enable = 1'b0;
    repeat (3) step(0, 8, 4, 0);
    i_rst_n = 1'b1;
    fifo_q.delete();
    fifo_q.push_back(64'h55);
    repeat (5) step(0, 8, 4, 0);
    check("idle_wait_enable", {o_busy, o_fifo_rd_en, o_de, o_video_data}, 0);
    repeat (5) step(1, 8, 4, 0);
    check("prime_wait_fifo", {o_busy, o_fifo_rd_en, o_de}, 3'b100);
    for (int i = 0; i < 40; i++) fifo_q.push_back(64'(i + 2));
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      step(1, 8, 4, 0);
      seen = o_fifo_rd_en;
    end
    check("prime_to_run_read", seen, 1);
    i_rst_n = 1'b0;
    i_enable = 1'b0;
    repeat (2) step(0, 8, 4, 0);
    i_rst_n = 1'b1;
    repeat (2) step(0, 8, 4, 0);
    check("final_idle", {o_busy, o_de, o_underflow_cnt}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
